// File: rtl/serial_xnor_comparator.sv
// Bit-serial WIDTH-bit comparator: XNOR vector, equality and mismatch count via start/busy/done.
// Optional early exit on the first mismatching bit when SERIAL_XNOR_EARLY_EXIT_EN is defined.
module serial_xnor_comparator #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic [WIDTH-1:0] xnor_vec,
    output logic [CNT_W-1:0] diff_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   wvec_q, wvec_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               eq_q, eq_d;
    logic [WIDTH-1:0]   xvec_q, xvec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_bit;
    logic               b_bit;
    logic               diff_bit;
    logic [IDX_W-1:0]   pos;
    logic               finish;
    logic               load;

    // Next-state, datapath and result publication
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        wvec_d   = wvec_q;
        wcnt_d   = wcnt_q;
        eq_d     = eq_q;
        xvec_d   = xvec_q;
        cnt_d    = cnt_q;
        finish   = 1'b0;
        load     = 1'b0;
        a_bit    = MSB_FIRST ? a_q[WIDTH-1] : a_q[0];
        b_bit    = MSB_FIRST ? b_q[WIDTH-1] : b_q[0];
        diff_bit = a_bit ^ b_bit;
        pos      = MSB_FIRST ? (IDX_W'(WIDTH - 1) - idx_q) : idx_q;

        case (state_q)
            ST_IDLE: begin
                load = start;
            end
            ST_SHIFT: begin
                wvec_d[pos] = ~diff_bit;
                wcnt_d      = wcnt_q + CNT_W'(diff_bit);
                a_d         = MSB_FIRST ? (a_q << 1) : (a_q >> 1);
                b_d         = MSB_FIRST ? (b_q << 1) : (b_q >> 1);
                idx_d       = idx_q + IDX_W'(1);
                finish      = (idx_q == IDX_W'(WIDTH - 1));
`ifdef SERIAL_XNOR_EARLY_EXIT_EN
                if (diff_bit) begin
                    finish = 1'b1;
                end
`endif
                if (finish) begin
                    state_d = ST_DONE;
                    eq_d    = (wcnt_d == '0);
                    xvec_d  = wvec_d;
                    cnt_d   = wcnt_d;
                end
            end
            ST_DONE: begin
                load    = start;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accepted start: capture operands and clear the working accumulators
        if (load) begin
            a_d     = a;
            b_d     = b;
            idx_d   = '0;
            wvec_d  = '0;
            wcnt_d  = '0;
            state_d = ST_SHIFT;
        end

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            wvec_q  <= '0;
            wcnt_q  <= '0;
            eq_q    <= 1'b0;
            xvec_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            wvec_q  <= wvec_d;
            wcnt_q  <= wcnt_d;
            eq_q    <= eq_d;
            xvec_q  <= xvec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign eq       = eq_q;
    assign xnor_vec = xvec_q;
    assign diff_cnt = cnt_q;

endmodule
